arb_req_queue: RTL and testbench

- Per-requester ingress buffer that sits directly upstream of the round-robin arbiter.
- Holds up to DEPTH beats per requester in independent FIFOs and drives the arbiter's one-hot-base `req` vector.
- Consumes the combinational `gnt` vector, pops the granted FIFO, and registers the winning beat onto a single valid/ready output with its source id.
- `req` is gated so the arbiter's base pointer only rotates on cycles when the granted beat is actually taken.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/arb_chan_fifo.sv | 46 ++++
 rtl/arb_req_queue.sv | 115 +++++++++++
 tb/tb_arb_req_queue.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared helpers for the arbiter family: id-width calculation and a
// lowest-bit-wins one-hot-to-index encoder.
package arb_pkg;

   // Widest request vector the encoder accepts; callers zero-extend into it.
   localparam int unsigned MaxReq = 64;

   function automatic int unsigned id_w(input int unsigned n);
      return (n < 2) ? 1 : unsigned'($clog2(n));
   endfunction

   // For a vector with several bits set, the lowest index wins.
   function automatic int unsigned onehot_to_idx(input logic [MaxReq-1:0] vec);
      int unsigned idx;
      idx = 0;
      for (int i = MaxReq - 1; i >= 0; i--) begin
         if (vec[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_chan_fifo.sv
// Single-channel synchronous FIFO with show-ahead head output; pointers carry
// one extra wrap bit so full and empty are distinguishable.
module arb_chan_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   logic [AW:0]           wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  do_wr, do_rd;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (do_rd) rd_ptr_q <= rd_ptr_q + PtrOne;
      end
   end

   // Storage is not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (!rst && do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/arb_req_queue.sv
// Per-requester ingress buffer feeding a round-robin arbiter, with a registered
// valid/ready output stage. Optional grant checking: ARB_REQ_QUEUE_GNT_CHECK_EN.
module arb_req_queue
   import arb_pkg::*;
#(
   parameter int unsigned REQ_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   localparam int unsigned ID_W      = id_w(REQ_WIDTH)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [REQ_WIDTH-1:0]            in_valid,
   input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
   output logic [REQ_WIDTH-1:0]            in_ready,
   output logic [REQ_WIDTH-1:0]            req,
   input  logic [REQ_WIDTH-1:0]            gnt,
   output logic                            out_valid,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [ID_W-1:0]                 out_id,
   input  logic                            out_ready,
   output logic                            gnt_err
);

   logic [REQ_WIDTH-1:0]  full, empty, pop, win;
   logic [DATA_WIDTH-1:0] head [REQ_WIDTH];
   logic [DATA_WIDTH-1:0] win_data;
   logic [ID_W-1:0]       win_idx;
   logic                  load_en, win_any;

   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [ID_W-1:0]       out_id_q;

   for (genvar i = 0; i < int'(REQ_WIDTH); i++) begin : g_chan
      arb_chan_fifo #(
         .DATA_WIDTH(DATA_WIDTH),
         .DEPTH     (DEPTH)
      ) u_fifo (
         .clk    (clk),
         .rst    (rst),
         .wr_en  (in_valid[i]),
         .wr_data(in_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .rd_en  (pop[i]),
         .rd_data(head[i]),
         .full   (full[i]),
         .empty  (empty[i])
      );

      assign pop[i] = win_any && (win_idx == ID_W'(i));
   end

   assign in_ready = ~full;

   // Requests drop while the output is stalled so the arbiter base stays put.
   assign load_en = !out_valid_q || out_ready;
   assign req     = ~empty & {REQ_WIDTH{load_en}};

   assign win     = gnt & req;
   assign win_any = |win;
   assign win_idx = ID_W'(onehot_to_idx(MaxReq'(win)));

   always_comb begin
      win_data = '0;
      for (int i = 0; i < int'(REQ_WIDTH); i++) begin
         if (pop[i]) win_data = head[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else if (load_en) begin
         if (win_any) begin
            out_valid_q <= 1'b1;
            out_data_q  <= win_data;
            out_id_q    <= win_idx;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

`ifdef ARB_REQ_QUEUE_GNT_CHECK_EN
   logic gnt_err_q, gnt_bad;

   // Grant outside req, multiple winners, or no grant despite a request.
   assign gnt_bad = (|(gnt & ~req)) || ($countones(win) > 1) || ((|req) && !(|gnt));

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_err_q <= 1'b0;
      end else if (gnt_bad) begin
         gnt_err_q <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && gnt_bad) $error("arb_req_queue: grant protocol error gnt=%b req=%b", gnt, req);
   end
`endif

   assign gnt_err = gnt_err_q;
`else
   assign gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue with a round-robin arbiter closing the req/gnt loop
// and a queue-based reference model checked every cycle.
module tb_arb_req_queue;

   localparam int RW = 4;
   localparam int DW = 8;
   localparam int DP = 2;

   logic            clk, rst;
   logic [RW-1:0]   in_valid, in_ready, req, gnt;
   logic [RW*DW-1:0] in_data;
   logic            out_valid, out_ready, gnt_err;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_id;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   arb_req_queue #(
      .REQ_WIDTH (RW),
      .DATA_WIDTH(DW),
      .DEPTH     (DP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .req      (req),
      .gnt      (gnt),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_id   (out_id),
      .out_ready(out_ready),
      .gnt_err  (gnt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Round-robin arbiter with one-hot base, base=0001 after reset.
   logic [RW-1:0]   base, arb_gnt, force_val;
   logic [2*RW-1:0] dbl, gdbl;
   logic            gnt_force;

   assign dbl     = {req, req};
   assign gdbl    = dbl & ~(dbl - {{RW{1'b0}}, base});
   assign arb_gnt = gdbl[2*RW-1:RW] | gdbl[RW-1:0];
   assign gnt     = gnt_force ? force_val : arb_gnt;

   always_ff @(posedge clk) begin
      if (rst) base <= 4'b0001;
      else if (arb_gnt != 0) base <= {arb_gnt[RW-2:0], arb_gnt[RW-1]};
   end

   always_ff @(posedge clk) cyc <= cyc + 1;

   // Reference model: one queue per requester, a round-robin pointer, an output register.
   logic [DW-1:0] mq [RW][$];
   bit            m_valid;
   logic [DW-1:0] m_data;
   int            m_id, m_ptr;
   bit            m_err, started;

   task automatic model_step();
      bit            load;
      logic [RW-1:0] mreq, g, win;
      bit            fullb [RW];
      int            pick, k, lo;
      if (rst) begin
         for (int i = 0; i < RW; i++) mq[i].delete();
         m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0; m_err = 0; started = 1;
         return;
      end
      load = !m_valid || out_ready;
      mreq = '0;
      for (int i = 0; i < RW; i++) begin
         fullb[i] = (mq[i].size() == DP);
         if (mq[i].size() != 0 && load) mreq[i] = 1'b1;
      end
      pick = -1;
      for (int off = 0; off < RW; off++) begin
         k = (m_ptr + off) % RW;
         if (pick < 0 && mreq[k]) pick = k;
      end
      g = '0;
      if (pick >= 0) begin
         g[pick] = 1'b1;
         m_ptr = (pick + 1) % RW;
      end
      if (gnt_force) g = force_val;
      win = g & mreq;
`ifdef ARB_REQ_QUEUE_GNT_CHECK_EN
      if ((g & ~mreq) != 0 || $countones(win) > 1 || (mreq != 0 && g == 0)) m_err = 1;
`endif
      if (load) begin
         if (win != 0) begin
            lo = -1;
            for (int i = RW - 1; i >= 0; i--) if (win[i]) lo = i;
            m_data  = mq[lo].pop_front();
            m_id    = lo;
            m_valid = 1;
         end else begin
            m_valid = 0;
         end
      end
      for (int i = 0; i < RW; i++) begin
         if (in_valid[i] && !fullb[i]) mq[i].push_back(in_data[i*DW +: DW]);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Log of beats actually taken downstream.
   int log_id [$];
   int log_data [$];
   int log_cyc [$];

   initial forever begin
      @(posedge clk);
      if (!rst && out_valid === 1'b1 && out_ready) begin
         log_id.push_back(int'(out_id));
         log_data.push_back(int'(out_data));
         log_cyc.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      logic [RW-1:0] e_rdy, e_req;
      @(negedge clk);
      if (started) begin
         for (int i = 0; i < RW; i++) begin
            e_rdy[i] = (mq[i].size() < DP);
            e_req[i] = (mq[i].size() != 0) && (!m_valid || out_ready);
         end
         check("model in_ready", 32'(in_ready), 32'(e_rdy));
         check("model req", 32'(req), 32'(e_req));
         check("model out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            check("model out_data", 32'(out_data), 32'(m_data));
            check("model out_id", 32'(out_id), m_id);
         end
         check("model gnt_err", 32'(gnt_err), 32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = '0;
      tick();
      rst = 1'b0;
      log_id.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   task automatic push_all(input logic [RW-1:0] mask, input int base_val);
      in_valid = mask;
      for (int i = 0; i < RW; i++) in_data[i*DW +: DW] = 8'(base_val + i);
   endtask

   task automatic check_seq8(input string tag, input bit b2b);
      check({tag, " count"}, 32'(log_id.size()), 8);
      if (log_id.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            check({tag, " id"}, 32'(log_id[k]), 32'(k % 4));
            check({tag, " data"}, 32'(log_data[k]), (k < 4) ? 32'h10 + 32'(k) : 32'h20 + 32'(k - 4));
            if (b2b) check({tag, " b2b"}, 32'(log_cyc[k]), 32'(log_cyc[0] + k));
         end
      end
   endtask

   initial begin
      bit exp_err;
`ifdef ARB_REQ_QUEUE_GNT_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
      gnt_force = 1'b0; force_val = '0;
      tick();
      do_reset();
      check("reset in_ready", 32'(in_ready), 32'hF);
      check("reset req", 32'(req), 0);
      check("reset out_valid", 32'(out_valid), 0);
      check("reset out_data", 32'(out_data), 0);
      check("reset out_id", 32'(out_id), 0);
      check("reset gnt_err", 32'(gnt_err), 0);

      // Single beat latency.
      in_valid = 4'b0001; in_data[7:0] = 8'hA0;
      tick();
      in_valid = '0;
      check("single req", 32'(req), 32'b0001);
      check("single early valid", 32'(out_valid), 0);
      tick();
      check("single out_valid", 32'(out_valid), 1);
      check("single out_data", 32'(out_data), 32'hA0);
      check("single out_id", 32'(out_id), 0);
      tick();
      check("single drained", 32'(out_valid), 0);

      // Full fill, back-to-back drain.
      do_reset();
      push_all(4'hF, 'h10); tick();
      push_all(4'hF, 'h20); tick();
      in_valid = '0;
      repeat (10) tick();
      check_seq8("fill", 1'b1);

      // Stall after first output: req gated, output held, base frozen.
      do_reset();
      push_all(4'hF, 'h10); tick();
      push_all(4'hF, 'h20); tick();
      in_valid = '0; out_ready = 1'b0;
      #1;
      for (int s = 0; s < 5; s++) begin
         check("stall req", 32'(req), 0);
         check("stall out_valid", 32'(out_valid), 1);
         check("stall out_data", 32'(out_data), 32'h10);
         check("stall out_id", 32'(out_id), 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("resume out_id", 32'(out_id), 1);
      check("resume out_data", 32'(out_data), 32'h11);
      repeat (10) tick();
      check_seq8("stall", 1'b0);

      // Full FIFO: pop frees space only on the next cycle, ordering preserved.
      do_reset();
      out_ready = 1'b0;
      in_valid = 4'b0001; in_data[7:0] = 8'h40; tick();
      in_valid = 4'b0100; in_data[23:16] = 8'h30; tick();
      in_data[23:16] = 8'h31; tick();
      in_data[23:16] = 8'h55; out_ready = 1'b1;
      #1;
      check("full in_ready2", 32'(in_ready[2]), 0);
      check("full req", 32'(req), 32'b0100);
      tick();
      check("after pop in_ready2", 32'(in_ready[2]), 1);
      check("after pop out_data", 32'(out_data), 32'h30);
      tick();
      in_valid = '0;
      check("pushpop out_data", 32'(out_data), 32'h31);
      check("pushpop in_ready2", 32'(in_ready[2]), 1);
      tick();
      check("new beat out_data", 32'(out_data), 32'h55);
      repeat (3) tick();
      check("full log count", 32'(log_id.size()), 4);
      if (log_id.size() == 4) begin
         check("full log0", 32'(log_data[0]), 32'h40);
         check("full log1", 32'(log_data[1]), 32'h30);
         check("full log2", 32'(log_data[2]), 32'h31);
         check("full log3", 32'(log_data[3]), 32'h55);
         check("full log id3", 32'(log_id[3]), 2);
      end

      // Mid-operation reset discards everything.
      do_reset();
      out_ready = 1'b0;
      push_all(4'hF, 'h10); tick();
      push_all(4'b1110, 'h20); tick();
      in_valid = '0;
      check("pre-rst out_valid", 32'(out_valid), 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("post-rst out_valid", 32'(out_valid), 0);
      check("post-rst req", 32'(req), 0);
      check("post-rst in_ready", 32'(in_ready), 32'hF);
      out_ready = 1'b1;
      log_id.delete(); log_data.delete(); log_cyc.delete();
      repeat (6) tick();
      check("post-rst no data", 32'(log_id.size()), 0);

      // Grant outside req.
      do_reset();
      in_valid = 4'b0010; in_data[15:8] = 8'h77; tick();
      in_valid = '0;
      check("gnt req", 32'(req), 32'b0010);
      gnt_force = 1'b1; force_val = 4'b0110;
      tick();
      gnt_force = 1'b0;
      check("gnt out_data", 32'(out_data), 32'h77);
      check("gnt out_id", 32'(out_id), 1);
      for (int s = 0; s < 3; s++) begin
         check("gnt_err sticky", 32'(gnt_err), 32'(exp_err));
         tick();
      end
      do_reset();
      check("gnt_err cleared", 32'(gnt_err), 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
